// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan driver.
// The hex decode table is active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NDIG = 8;

    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    localparam seg_t HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Value/hold input and anode/segment drive of the scan driver, bundled.
// The driver takes the slave modport; whoever supplies the value takes master.
interface seg7_scan_driver_if;
    import seg7_pkg::*;

    logic [31:0] value;
    logic        hold;
    logic [7:0]  an;
    seg_t        seg;
    logic        dp;

    modport master (output value, output hold, input an, input seg, input dp);
    modport slave  (input value, input hold, output an, output seg, output dp);

endinterface

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment pattern decoder.
module hex_to_7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Scans a 32-bit value as 8 hex digits on a common-anode, active-low display.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens slots above the top non-zero digit.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
)(
    input  logic               clk,
    input  logic               reset,
    seg7_scan_driver_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PW-1:0] presc_reg, presc_next;
    logic [2:0]    idx_reg, idx_next;
    logic [31:0]   shadow_reg, shadow_next;
    logic [7:0]    an_reg, an_next;
    seg_t          seg_reg, seg_next;

    logic          tick;
    logic          frame_end;
    logic [3:0]    nib [NDIG];
    logic [3:0]    cur_nib;
    seg_t          dec_seg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib[gi] = shadow_reg[4*gi +: 4];
        end
    endgenerate

    assign cur_nib = nib[idx_reg];

    hex_to_7seg u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    assign tick      = (presc_reg == PW'(REFRESH_DIV - 1));
    assign frame_end = tick && (idx_reg == 3'd7);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Highest non-zero digit; an all-zero shadow still lights digit 0.
    logic [2:0] msd;
    always_comb begin
        msd = 3'd0;
        for (int i = 0; i < NDIG; i++) begin
            if (nib[i] != 4'h0) msd = 3'(i);
        end
    end
`endif

    always_comb begin
        presc_next  = tick ? '0 : presc_reg + 1'b1;
        idx_next    = tick ? idx_reg + 3'd1 : idx_reg;
        // The whole frame is shown from one snapshot taken at its boundary.
        shadow_next = (frame_end && !bus.hold) ? bus.value : shadow_reg;
        an_next     = ~(8'b1 << idx_reg);
        seg_next    = dec_seg;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (idx_reg > msd) begin
            an_next  = AN_OFF;
            seg_next = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg  <= '0;
            idx_reg    <= 3'd0;
            shadow_reg <= 32'h0;
            an_reg     <= AN_OFF;
            seg_reg    <= SEG_BLANK;
        end else begin
            presc_reg  <= presc_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            an_reg     <= an_next;
            seg_reg    <= seg_next;
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with REFRESH_DIV=4; expected per-cycle
// anode/segment pairs are queued ahead of time and compared as cycles elapse.
module tb_seg7_scan_driver;

    localparam int RDIV = 4;
    localparam logic [31:0] K = 32'h9E3779B9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(.REFRESH_DIV(RDIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    bit cnt_mode = 1'b0;
    logic [14:0] exp_q [$];

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    // Queue the first ncyc cycles of a frame that displays v.
    task automatic push_frame(input logic [31:0] v, input int ncyc = 8 * RDIV);
        int msd = 0;
        int n = 0;
        logic [7:0] a;
        logic [6:0] s;
        for (int i = 0; i < 8; i++)
            if (v[4*i +: 4] != 4'h0) msd = i;
        for (int d = 0; d < 8; d++) begin
            a = ~(8'h01 << d);
            s = ref_seg(v[4*d +: 4]);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
            if (d > msd) begin
                a = 8'hFF;
                s = 7'h7F;
            end
`endif
            for (int c = 0; c < RDIV; c++) begin
                if (n < ncyc) exp_q.push_back({a, s});
                n++;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s edge=%0d got %h want %h", tag, ecnt, obs, expv);
        end
    endtask

    task automatic run(input int n);
        logic [14:0] e;
        for (int i = 0; i < n; i++) begin
            if (cnt_mode) bus.value = K * 32'(ecnt);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL queue_empty edge=%0d got none want entry", ecnt);
            end else begin
                e = exp_q.pop_front();
                check("an", 32'(bus.an), 32'(e[14:7]));
                check("seg", 32'(bus.seg), 32'(e[6:0]));
                check("dp", 32'(bus.dp), 32'd1);
            end
            ecnt++;
        end
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_an"}, 32'(bus.an), 32'hFF);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_dp"}, 32'(bus.dp), 32'd1);
    endtask

    initial begin
        bus.value = 32'h89ABCDEF;
        bus.hold  = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_dark("reset");
        end
        reset = 1'b0;
        ecnt  = 0;

        // Frame 0 shows the cleared shadow, frame 1 the constant value.
        push_frame(32'h0);
        push_frame(32'h89ABCDEF);
        run(64);

        // Value changes every cycle; each frame must show the frame-end sample.
        push_frame(32'h89ABCDEF);
        push_frame(K * 32'd95);
        push_frame(K * 32'd127);
        cnt_mode = 1'b1;
        run(96);
        cnt_mode = 1'b0;

        bus.value = 32'h12345678;
        push_frame(K * 32'd159);
        run(32);

        // Held across two frame ends, then released.
        push_frame(32'h12345678);
        push_frame(32'h12345678);
        bus.hold  = 1'b1;
        bus.value = 32'h87654321;
        run(64);
        push_frame(32'h12345678);
        push_frame(32'h87654321);
        bus.hold = 1'b0;
        run(64);

        // Reset lands while digit 5 of an all-F frame is lit.
        bus.value = 32'hFFFFFFFF;
        push_frame(32'h87654321);
        push_frame(32'hFFFFFFFF, 21);
        run(53);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_dark("midreset");
        reset = 1'b0;
        ecnt  = 0;
        push_frame(32'h0);
        run(32);

        bus.value = 32'h000000A5;
        push_frame(32'hFFFFFFFF);
        push_frame(32'h000000A5);
        run(64);
        bus.value = 32'h0;
        push_frame(32'h000000A5);
        push_frame(32'h0);
        run(64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
